// File: rtl/tdm_demux4.sv
// Four-channel TDM receiver: rebuilds WIDTH-bit channel words from a sync-framed
// serial stream, with hunt/lock alignment, flywheel tolerance and sync error flags.
module tdm_demux4 #(
    parameter int WIDTH    = 8,
    parameter int MISS_MAX = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             din,
    input  logic             sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int FRAME = 4 * WIDTH;
    localparam int PW    = $clog2(FRAME);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t                  state, state_nx;
    logic [PW-1:0]           p, p_nx;
    logic [2:0]              miss, miss_nx;
    logic [3:0][WIDTH-1:0]   sh, sh_nx;
    logic                    done, done_nx;
    logic                    err_nx;
    logic                    accept, restart;
    logic [1:0]              slot, acc_slot;

    assign slot   = 2'(p / PW'(WIDTH));
    assign locked = (state == LOCKED);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        p_nx     = p;
        miss_nx  = miss;
        sh_nx    = sh;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        accept   = 1'b0;
        restart  = 1'b0;
        acc_slot = slot;

        if (en) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        accept   = 1'b1;
                        restart  = 1'b1;
                        acc_slot = 2'd0;
                        state_nx = LOCKED;
                        miss_nx  = 3'd0;
                    end
                end
                LOCKED: begin
                    if (p == '0) begin
                        if (sync) begin
                            accept  = 1'b1;
                            miss_nx = 3'd0;
                        end else if ((miss + 3'd1) == 3'(MISS_MAX)) begin
                            err_nx   = 1'b1;
                            state_nx = HUNT;
                            miss_nx  = 3'd0;
                        end else begin
                            // Flywheel: keep the frame going on the expected timing.
                            err_nx  = 1'b1;
                            accept  = 1'b1;
                            miss_nx = miss + 3'd1;
                        end
                    end else if (sync) begin
                        err_nx   = 1'b1;
                        accept   = 1'b1;
                        restart  = 1'b1;
                        acc_slot = 2'd0;
                        sh_nx    = '0;
                    end else begin
                        accept = 1'b1;
                    end
                end
                default: state_nx = HUNT;
            endcase

            if (accept) begin
                sh_nx[acc_slot] = {sh_nx[acc_slot][WIDTH-2:0], din};
                if (restart) begin
                    p_nx = PW'(1);
                end else if (p == PW'(FRAME - 1)) begin
                    p_nx    = '0;
                    done_nx = 1'b1;
                end else begin
                    p_nx = p + PW'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HUNT;
            p           <= '0;
            miss        <= 3'd0;
            sh          <= '0;
            done        <= 1'b0;
            sync_err    <= 1'b0;
            frame_valid <= 1'b0;
            ch0         <= '0;
            ch1         <= '0;
            ch2         <= '0;
            ch3         <= '0;
        end else begin
            state    <= state_nx;
            p        <= p_nx;
            miss     <= miss_nx;
            sh       <= sh_nx;
            done     <= done_nx;
            sync_err <= err_nx;
            // The completed frame is published one edge later regardless of en,
            // so the strobe timing does not depend on the sample rate.
            frame_valid <= done;
            if (done) begin
                ch0 <= sh[0];
                ch1 <= sh[1];
                ch2 <= sh[2];
                ch3 <= sh[3];
            end
        end
    end

endmodule
